regfile_param: RTL

Parametrised, clocked register file for the datapath: two asynchronous read ports and one synchronous write port. Supports sub-word write modes, a hardwired-zero register 0, and a sequential clear engine that zeroes every entry after reset. It replaces the fixed 32×32 register block in the decode stage and stays drop-in compatible at `DATA_W=32`, `ADDR_W=5`.

---
 rtl/regfile_param.sv | 98 +++++++++
 1 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: 2 async read ports, 1 sync write port with sub-word modes,
// hardwired-zero r0, and a post-reset clear engine. Optional REGFILE_BYPASS_EN adds write-to-read forwarding.
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [1:0]        wmode,
  output logic              busy,
  output logic              wr_ack
);

  // state | meaning
  // IDLE  | normal read/write operation
  // CLEAR | zeroing mem[clr_ptr], one entry per cycle; writes refused, reads forced to 0
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              wr_ack_q, wr_ack_d;
  logic              clr_we;
  logic              wr_accept;
  logic [DATA_W-1:0] old_val;
  logic [DATA_W-1:0] merged;

  assign busy   = (state_q == CLEAR);
  assign wr_ack = wr_ack_q;

  assign wr_accept = regWrite && !busy && (write_reg != '0) && !rst;
  assign clr_we    = busy && !rst;
  assign old_val   = mem_q[write_reg];

  always_comb begin
    merged = old_val;
    unique case (wmode)
      2'b00: merged = write_data;
      2'b01: merged[7:0] = write_data[7:0];
      2'b10: merged[15:0] = write_data[15:0];
      2'b11: merged = {{(DATA_W-8){write_data[7]}}, write_data[7:0]};
      default: merged = old_val;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_ack_d  = wr_accept;
    if (rst) begin
      state_d   = CLEAR;
      clr_ptr_d = '0;
      wr_ack_d  = 1'b0;
    end else if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST_PTR) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_ptr_q <= clr_ptr_d;
    wr_ack_q  <= wr_ack_d;
  end

  // Clear and normal writes are mutually exclusive through busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (wr_accept) begin
      mem_q[write_reg] <= merged;
    end
  end

  always_comb begin
    read_data1 = mem_q[read_reg1];
    read_data2 = mem_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
    if (wr_accept && (read_reg1 == write_reg)) read_data1 = merged;
    if (wr_accept && (read_reg2 == write_reg)) read_data2 = merged;
`endif
    if (busy || (read_reg1 == '0)) read_data1 = '0;
    if (busy || (read_reg2 == '0)) read_data2 = '0;
  end

endmodule
